// File: rtl/sd_wb_pkg.sv
// Shared constants for the SD emulator Wishbone backing store:
// cycle/burst type codes, FSM state encoding and the default RAM address width.
package sd_wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SINGLE = 2'd1;
   localparam logic [1:0] ST_BURST  = 2'd2;

   localparam int MEM_WORDS_DEFAULT = 4096;
   localparam int ADDR_W            = $clog2(MEM_WORDS_DEFAULT);

endpackage

// File: rtl/sd_wb_store_ram.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables.
// Read-before-write, no reset, so it maps onto block RAM.
module sd_wb_store_ram #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    we,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/sd_wb_store.sv
// Wishbone B3 slave block memory with registered feedback: classic cycles and
// linear incrementing bursts at one beat per clock; out-of-range beats are acked and counted.
module sd_wb_store
   import sd_wb_pkg::*;
#(
   parameter int          MEM_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk_50,
   input  logic        reset_n,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic [31:0] wbs_dat_o,
   input  logic [3:0]  wbs_sel_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   output logic        wbs_ack_o,
   input  logic [2:0]  wbs_cti_i,
   input  logic [1:0]  wbs_bte_i,
   output logic [15:0] oor_cnt,
   output logic        busy
);

   localparam int          AW    = $clog2(MEM_WORDS);
   localparam logic [31:0] DEPTH = 32'(MEM_WORDS);

   logic [1:0]  state;
   logic [31:0] baddr;
   logic        burst_lo;
   logic        single_oor;
   logic        rd_ok_q;
   logic [31:0] ram_q;

   logic [31:0] idx;
   logic        adr_lo;
   logic        idx_ok;
   logic        accept;
   logic        is_burst;
   logic        beat;
   logic        baddr_ok;
   logic        count_oor;
   logic [31:0] ram_word;
   logic [3:0]  ram_we;
   logic        rd_ok;

   assign idx      = (wbs_adr_i - BASE_ADDR) >> 2;
   assign adr_lo   = wbs_adr_i < BASE_ADDR;
   assign idx_ok   = !adr_lo && (idx < DEPTH);
   assign accept   = (state == ST_IDLE) && wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
   assign is_burst = (wbs_cti_i == CTI_INCR) && (wbs_bte_i == BTE_LINEAR);
   assign beat     = wbs_cyc_i && wbs_stb_i && wbs_ack_o;
   assign baddr_ok = !burst_lo && (baddr < DEPTH);

   assign count_oor = beat && (((state == ST_SINGLE) && single_oor) ||
                               ((state == ST_BURST) && !baddr_ok));

   // Burst reads look one word ahead on every completed beat so ack can stay high.
   always_comb begin
      ram_word = idx;
      ram_we   = 4'b0000;
      rd_ok    = idx_ok;
      case (state)
         ST_IDLE: begin
            if (accept && !is_burst && wbs_we_i && idx_ok) ram_we = wbs_sel_i;
         end
         ST_BURST: begin
            ram_word = (beat && !wbs_we_i) ? baddr + 32'd1 : baddr;
            rd_ok    = !burst_lo && (ram_word < DEPTH);
            if (beat && wbs_we_i && baddr_ok) ram_we = wbs_sel_i;
         end
         default: ;
      endcase
      if (!reset_n) ram_we = 4'b0000;
   end

   sd_wb_store_ram #(
      .AW (AW)
   ) u_ram (
      .clk   (clk_50),
      .addr  (ram_word[AW-1:0]),
      .we    (ram_we),
      .wdata (wbs_dat_i),
      .rdata (ram_q)
   );

   always_ff @(posedge clk_50) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         wbs_ack_o  <= 1'b0;
         baddr      <= 32'd0;
         burst_lo   <= 1'b0;
         single_oor <= 1'b0;
         rd_ok_q    <= 1'b0;
         oor_cnt    <= 16'd0;
      end else begin
         rd_ok_q <= rd_ok;
         if (count_oor && (oor_cnt != 16'hFFFF)) oor_cnt <= oor_cnt + 16'd1;
         case (state)
            ST_IDLE: begin
               wbs_ack_o <= accept;
               if (accept) begin
                  if (is_burst) begin
                     state    <= ST_BURST;
                     baddr    <= idx;
                     burst_lo <= adr_lo;
                  end else begin
                     state      <= ST_SINGLE;
                     single_oor <= !idx_ok;
                  end
               end
            end
            ST_SINGLE: begin
               state     <= ST_IDLE;
               wbs_ack_o <= 1'b0;
            end
            ST_BURST: begin
               if (!wbs_cyc_i) begin
                  state     <= ST_IDLE;
                  wbs_ack_o <= 1'b0;
               end else begin
                  if (beat) baddr <= baddr + 32'd1;
                  if (beat && (wbs_cti_i == CTI_EOB)) begin
                     state     <= ST_IDLE;
                     wbs_ack_o <= 1'b0;
                  end else begin
                     wbs_ack_o <= wbs_stb_i;
                  end
               end
            end
            default: begin
               state     <= ST_IDLE;
               wbs_ack_o <= 1'b0;
            end
         endcase
      end
   end

   assign wbs_dat_o = rd_ok_q ? ram_q : 32'h0;
   assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_sd_wb_store.sv
// Directed bench for sd_wb_store: single, partial, burst, wait-state,
// out-of-range and mid-burst reset scenarios with hand-derived expectations.
module tb_sd_wb_store;
   import sd_wb_pkg::*;

   localparam int          MW   = 1 << ADDR_W;
   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk_50;
   logic        reset_n;
   logic [31:0] adr;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic [3:0]  sel;
   logic        cyc;
   logic        stb;
   logic        we;
   logic        ack;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [15:0] oor_cnt;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_mem [0:MW-1];
   logic [31:0] wdat [0:255];
   logic [31:0] rdat [0:255];

   sd_wb_store #(
      .MEM_WORDS (MW),
      .BASE_ADDR (BASE)
   ) dut (
      .clk_50    (clk_50),
      .reset_n   (reset_n),
      .wbs_adr_i (adr),
      .wbs_dat_i (dat_i),
      .wbs_dat_o (dat_o),
      .wbs_sel_i (sel),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_we_i  (we),
      .wbs_ack_o (ack),
      .wbs_cti_i (cti),
      .wbs_bte_i (bte),
      .oor_cnt   (oor_cnt),
      .busy      (busy)
   );

   // clock / reset
   initial begin
      clk_50 = 1'b0;
      forever #5 clk_50 = ~clk_50;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic bus_idle();
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
      adr = 32'h0; dat_i = 32'h0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
   endtask

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] i;
      i = (a - BASE) >> 2;
      if (a >= BASE && i < 32'(MW)) begin
         for (int b = 0; b < 4; b++) begin
            if (s[b]) exp_mem[i[ADDR_W-1:0]][8*b +: 8] = d[8*b +: 8];
         end
      end
   endtask

   task automatic wb_single(input bit w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] c, input logic [1:0] b,
                            output logic [31:0] rd, output int lat, output logic busy_after);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s; cti = c; bte = b;
      lat = 0;
      rd  = 32'h0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_50);
         if (ack) break;
         lat++;
         @(posedge clk_50); #1;
      end
      rd = dat_o;
      if (w) model_write(a, d, s);
      @(posedge clk_50); #1;
      bus_idle();
      @(negedge clk_50);
      busy_after = busy;
      @(posedge clk_50); #1;
   endtask

   task automatic wb_burst(input bit w, input int start, input int n,
                           input int wait_after, input int wait_len,
                           output int beats, output int first_lat, output int span,
                           output int gap_low, output logic post_busy, output logic post_ack);
      int cyc_i;
      int waited;
      int last;
      beats = 0; first_lat = -1; span = -1; gap_low = 0;
      cyc_i = 0; waited = 0; last = 0;
      cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; bte = BTE_LINEAR;
      adr = BASE + 32'(start) * 4; dat_i = wdat[0];
      cti = (n == 1) ? CTI_EOB : CTI_INCR;
      while (beats < n && cyc_i < 2000) begin
         @(negedge clk_50);
         if (stb && ack) begin
            if (beats == 0) first_lat = cyc_i;
            last = cyc_i;
            rdat[beats] = dat_o;
            if (w) model_write(BASE + 32'(start + beats) * 4, wdat[beats], 4'hF);
            beats++;
         end else if (beats > 0 && !ack) begin
            gap_low++;
         end
         @(posedge clk_50); #1;
         cyc_i++;
         if (beats < n) begin
            adr   = BASE + 32'(start + beats) * 4;
            dat_i = wdat[beats];
            cti   = (beats == n - 1) ? CTI_EOB : CTI_INCR;
            if (wait_len > 0 && beats == wait_after + 1 && waited < wait_len) begin
               stb = 1'b0;
               waited++;
            end else begin
               stb = 1'b1;
            end
         end
      end
      bus_idle();
      if (first_lat >= 0) span = last - first_lat;
      @(negedge clk_50);
      post_busy = busy;
      post_ack  = ack;
      @(posedge clk_50); #1;
   endtask

   // scenarios
   task automatic test_reset();
      reset_n = 1'b0;
      bus_idle();
      repeat (3) @(posedge clk_50);
      @(negedge clk_50);
      n_cmp++; if (ack !== 1'b0)      begin n_err++; $display("FAIL reset_ack got=%b exp=0", ack); end
      n_cmp++; if (dat_o !== 32'h0)   begin n_err++; $display("FAIL reset_dat got=%h exp=00000000", dat_o); end
      n_cmp++; if (oor_cnt !== 16'h0) begin n_err++; $display("FAIL reset_oor got=%0d exp=0", oor_cnt); end
      n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      @(posedge clk_50); #1;
      reset_n = 1'b1;
      @(posedge clk_50); #1;
   endtask

   task automatic test_single();
      logic [31:0] rd;
      int          lat;
      logic        ba;
      wb_single(1'b1, BASE + 32'd8, 32'hDEADBEEF, 4'hF, CTI_CLASSIC, BTE_LINEAR, rd, lat, ba);
      n_cmp++; if (lat !== 1)   begin n_err++; $display("FAIL single_wr_lat got=%0d exp=1", lat); end
      n_cmp++; if (ba !== 1'b0) begin n_err++; $display("FAIL single_wr_busy_after got=%b exp=0", ba); end
      wb_single(1'b0, BASE + 32'd8, 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR, rd, lat, ba);
      n_cmp++; if (lat !== 1)             begin n_err++; $display("FAIL single_rd_lat got=%0d exp=1", lat); end
      n_cmp++; if (rd !== 32'hDEADBEEF)   begin n_err++; $display("FAIL single_rd_data got=%h exp=deadbeef", rd); end
   endtask

   task automatic test_partial();
      logic [31:0] rd;
      int          lat;
      logic        ba;
      wb_single(1'b1, BASE + 32'd12, 32'hFFFFFFFF, 4'hF, CTI_CLASSIC, BTE_LINEAR, rd, lat, ba);
      wb_single(1'b1, BASE + 32'd12, 32'h11223344, 4'b0101, CTI_CLASSIC, BTE_LINEAR, rd, lat, ba);
      wb_single(1'b0, BASE + 32'd12, 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR, rd, lat, ba);
      n_cmp++; if (rd !== 32'hFF22FF44) begin n_err++; $display("FAIL partial_data got=%h exp=ff22ff44", rd); end
      wb_single(1'b1, BASE + 32'd12, 32'h00000000, 4'b0000, CTI_CLASSIC, BTE_LINEAR, rd, lat, ba);
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL sel0_lat got=%0d exp=1", lat); end
      wb_single(1'b0, BASE + 32'd12, 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR, rd, lat, ba);
      n_cmp++; if (rd !== 32'hFF22FF44) begin n_err++; $display("FAIL sel0_data got=%h exp=ff22ff44", rd); end
   endtask

   task automatic test_cti_bte();
      logic [31:0] rd;
      int          lat;
      logic        ba;
      wb_single(1'b1, BASE + 32'd40, 32'h0BADF00D, 4'hF, CTI_INCR, 2'b01, rd, lat, ba);
      n_cmp++; if (lat !== 1)   begin n_err++; $display("FAIL incr_bte1_lat got=%0d exp=1", lat); end
      n_cmp++; if (ba !== 1'b0) begin n_err++; $display("FAIL incr_bte1_busy_after got=%b exp=0", ba); end
      wb_single(1'b0, BASE + 32'd40, 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR, rd, lat, ba);
      n_cmp++; if (rd !== 32'h0BADF00D) begin n_err++; $display("FAIL incr_bte1_data got=%h exp=0badf00d", rd); end
   endtask

   task automatic test_burst_128();
      int   beats, first_lat, span, gap_low;
      logic pb, pa;
      for (int k = 0; k < 128; k++) wdat[k] = 32'h1000_0000 + 32'(k) * 32'h0001_0003;
      wb_burst(1'b1, 0, 128, 0, 0, beats, first_lat, span, gap_low, pb, pa);
      n_cmp++; if (beats !== 128)   begin n_err++; $display("FAIL wburst_beats got=%0d exp=128", beats); end
      n_cmp++; if (first_lat !== 1) begin n_err++; $display("FAIL wburst_first_lat got=%0d exp=1", first_lat); end
      n_cmp++; if (span !== 127)    begin n_err++; $display("FAIL wburst_span got=%0d exp=127", span); end
      n_cmp++; if (pb !== 1'b0)     begin n_err++; $display("FAIL wburst_post_busy got=%b exp=0", pb); end
      wb_burst(1'b0, 0, 128, 0, 0, beats, first_lat, span, gap_low, pb, pa);
      n_cmp++; if (beats !== 128)   begin n_err++; $display("FAIL rburst_beats got=%0d exp=128", beats); end
      n_cmp++; if (first_lat !== 1) begin n_err++; $display("FAIL rburst_first_lat got=%0d exp=1", first_lat); end
      n_cmp++; if (span !== 127)    begin n_err++; $display("FAIL rburst_span got=%0d exp=127", span); end
      n_cmp++; if (gap_low !== 0)   begin n_err++; $display("FAIL rburst_gap got=%0d exp=0", gap_low); end
      n_cmp++; if (pb !== 1'b0)     begin n_err++; $display("FAIL rburst_post_busy got=%b exp=0", pb); end
      n_cmp++; if (pa !== 1'b0)     begin n_err++; $display("FAIL rburst_post_ack got=%b exp=0", pa); end
      for (int k = 0; k < 128; k++) begin
         n_cmp++;
         if (rdat[k] !== 32'h1000_0000 + 32'(k) * 32'h0001_0003) begin
            n_err++;
            $display("FAIL rburst_data[%0d] got=%h exp=%h", k, rdat[k], 32'h1000_0000 + 32'(k) * 32'h0001_0003);
         end
      end
   endtask

   task automatic test_wait_state();
      int   beats, first_lat, span, gap_low;
      logic pb, pa;
      wb_burst(1'b0, 0, 10, 5, 3, beats, first_lat, span, gap_low, pb, pa);
      n_cmp++; if (beats !== 10)  begin n_err++; $display("FAIL wait_beats got=%0d exp=10", beats); end
      n_cmp++; if (gap_low !== 3) begin n_err++; $display("FAIL wait_ack_low got=%0d exp=3", gap_low); end
      n_cmp++; if (span !== 13)   begin n_err++; $display("FAIL wait_span got=%0d exp=13", span); end
      for (int k = 0; k < 10; k++) begin
         n_cmp++;
         if (rdat[k] !== exp_mem[k]) begin
            n_err++;
            $display("FAIL wait_data[%0d] got=%h exp=%h", k, rdat[k], exp_mem[k]);
         end
      end
   endtask

   task automatic test_oor();
      logic [31:0] rd;
      int          lat;
      logic        ba;
      int          beats, first_lat, span, gap_low;
      logic        pb, pa;
      n_cmp++; if (oor_cnt !== 16'd0) begin n_err++; $display("FAIL oor_start got=%0d exp=0", oor_cnt); end
      wb_single(1'b1, BASE + 32'(MW - 2) * 4, 32'hCAFE0001, 4'hF, CTI_CLASSIC, BTE_LINEAR, rd, lat, ba);
      wb_single(1'b1, BASE + 32'(MW - 1) * 4, 32'hCAFE0002, 4'hF, CTI_CLASSIC, BTE_LINEAR, rd, lat, ba);
      wb_burst(1'b0, MW - 2, 4, 0, 0, beats, first_lat, span, gap_low, pb, pa);
      n_cmp++; if (beats !== 4)            begin n_err++; $display("FAIL oor_burst_beats got=%0d exp=4", beats); end
      n_cmp++; if (rdat[0] !== 32'hCAFE0001) begin n_err++; $display("FAIL oor_burst_d0 got=%h exp=cafe0001", rdat[0]); end
      n_cmp++; if (rdat[1] !== 32'hCAFE0002) begin n_err++; $display("FAIL oor_burst_d1 got=%h exp=cafe0002", rdat[1]); end
      n_cmp++; if (rdat[2] !== 32'h0)        begin n_err++; $display("FAIL oor_burst_d2 got=%h exp=00000000", rdat[2]); end
      n_cmp++; if (rdat[3] !== 32'h0)        begin n_err++; $display("FAIL oor_burst_d3 got=%h exp=00000000", rdat[3]); end
      n_cmp++; if (oor_cnt !== 16'd2)        begin n_err++; $display("FAIL oor_burst_cnt got=%0d exp=2", oor_cnt); end
      wb_single(1'b0, BASE - 32'd4, 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR, rd, lat, ba);
      n_cmp++; if (lat !== 1)         begin n_err++; $display("FAIL oor_below_lat got=%0d exp=1", lat); end
      n_cmp++; if (rd !== 32'h0)      begin n_err++; $display("FAIL oor_below_data got=%h exp=00000000", rd); end
      n_cmp++; if (oor_cnt !== 16'd3) begin n_err++; $display("FAIL oor_below_cnt got=%0d exp=3", oor_cnt); end
      wb_single(1'b1, BASE + 32'(MW) * 4, 32'h12345678, 4'hF, CTI_CLASSIC, BTE_LINEAR, rd, lat, ba);
      n_cmp++; if (oor_cnt !== 16'd4) begin n_err++; $display("FAIL oor_above_cnt got=%0d exp=4", oor_cnt); end
      wb_single(1'b0, BASE, 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR, rd, lat, ba);
      n_cmp++; if (rd !== 32'h1000_0000) begin n_err++; $display("FAIL oor_no_alias got=%h exp=10000000", rd); end
   endtask

   task automatic test_reset_mid_burst();
      logic [31:0] rd;
      int          lat;
      logic        ba;
      int          beats;
      for (int k = 0; k < 8; k++) wdat[k] = 32'h7700_0000 + 32'(k);
      beats = 0;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; bte = BTE_LINEAR; cti = CTI_INCR;
      adr = BASE; dat_i = wdat[0];
      for (int c = 0; c < 50 && beats < 3; c++) begin
         @(negedge clk_50);
         if (stb && ack) begin
            model_write(BASE + 32'(beats) * 4, wdat[beats], 4'hF);
            beats++;
         end
         @(posedge clk_50); #1;
         adr = BASE + 32'(beats) * 4;
         dat_i = wdat[beats];
      end
      n_cmp++; if (beats !== 3) begin n_err++; $display("FAIL rstmid_beats got=%0d exp=3", beats); end
      reset_n = 1'b0;
      @(posedge clk_50); #1;
      bus_idle();
      @(negedge clk_50);
      n_cmp++; if (ack !== 1'b0)      begin n_err++; $display("FAIL rstmid_ack got=%b exp=0", ack); end
      n_cmp++; if (dat_o !== 32'h0)   begin n_err++; $display("FAIL rstmid_dat got=%h exp=00000000", dat_o); end
      n_cmp++; if (oor_cnt !== 16'h0) begin n_err++; $display("FAIL rstmid_oor got=%0d exp=0", oor_cnt); end
      n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      @(posedge clk_50); #1;
      reset_n = 1'b1;
      @(posedge clk_50); #1;
      for (int k = 0; k < 8; k++) begin
         wb_single(1'b0, BASE + 32'(k) * 4, 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR, rd, lat, ba);
         n_cmp++;
         if (rd !== exp_mem[k]) begin
            n_err++;
            $display("FAIL rstmid_word[%0d] got=%h exp=%h", k, rd, exp_mem[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_partial();
      test_cti_bte();
      test_burst_128();
      test_wait_state();
      test_oor();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sd_wb_store.md
# sd_wb_store

Wishbone B3 slave backing store for the SD device emulator. It consumes the bus mastered by `sd_top` (the `wbm_*` port) and presents a word-addressed, byte-enabled block memory in place of external DRAM. It serves classic single cycles and linear incrementing bursts with registered feedback, at up to one beat per clock. Out-of-range accesses complete harmlessly and are counted.

## Interface
Parameters:
- `MEM_WORDS`, 4096: depth in 32-bit words; must be a power of two, ≥ 128 (one 512-byte block).
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.

Ports:
- `clk_50`  in  1  sole clock; the bus runs on `wbm_clk_o`, which is `clk_50`.
- `reset_n`  in  1  synchronous, active-low reset.
- `wbs_adr_i`  in  32  byte address; bits [1:0] are ignored.
- `wbs_dat_i`  in  32  write data.
- `wbs_dat_o`  out  32  read data.
- `wbs_sel_i`  in  4  byte enables; bit n selects `dat[8n+7:8n]`.
- `wbs_cyc_i`  in  1  cycle valid.
- `wbs_stb_i`  in  1  strobe.
- `wbs_we_i`  in  1  1 = write.
- `wbs_ack_o`  out  1  beat acknowledge.
- `wbs_cti_i`  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
- `wbs_bte_i`  in  2  burst type; only 00 (linear) is treated as a burst.
- `oor_cnt`  out  16  saturating count of out-of-range beats.
- `busy`  out  1  high while not in IDLE.

## Operation
- Word index: `idx = (wbs_adr_i - BASE_ADDR) >> 2`, computed at 32 bits. In range iff `wbs_adr_i >= BASE_ADDR` and `idx < MEM_WORDS`.
- Out-of-range beat:
  - Still acknowledged.
  - A read returns 32'h0; a write is dropped.
  - `oor_cnt` increments and holds at 16'hFFFF.
- Writes update only the bytes selected by `wbs_sel_i`. `sel = 0000` is acknowledged with no memory change.
- States: IDLE, SINGLE, BURST.
- IDLE → SINGLE when `cyc & stb & !ack` and not (`cti == 010 & bte == 00`).
  - Write: memory is written in the accept cycle.
  - Read: the RAM read is issued in the accept cycle.
  - Next cycle: `ack = 1`, `wbs_dat_o` valid, state returns to IDLE.
- IDLE → BURST when `cyc & stb & !ack & cti == 010 & bte == 00`.
  - The burst address counter `baddr` loads `idx`.
  - Beat k is acknowledged one cycle after its strobe is seen.
  - On each cycle with `stb & ack`: the beat completes, a write uses `baddr`, and `baddr` increments.
  - Reads prefetch `baddr + 1` so that `ack` can stay high on consecutive cycles.
  - The beat completed with `cti == 111` is the last one. `ack` drops on the next cycle and the state returns to IDLE.
- `cti == 010` with `bte != 00` is served as a single cycle.
- Master wait state (`stb` low, `cyc` high, in BURST): `ack` goes low the next cycle; the state and `baddr` hold. A re-asserted `stb` is acknowledged one cycle later.
- `cyc` low in any state: return to IDLE next cycle, `ack = 0`. An unacknowledged write is not performed.
- `baddr` reaching `MEM_WORDS`: the beats that follow are out-of-range. There is no wrap to word 0.
- Reset:
  - `wbs_ack_o = 0`, `wbs_dat_o = 0`, `oor_cnt = 0`, `busy = 0`, state IDLE, `baddr = 0`.
  - Memory contents are neither cleared nor guaranteed.
  - Reset asserted mid-burst takes effect on the next edge; no later beat writes memory.

## Timing
- Single read or write: strobe seen at cycle N, ack (and read data) at N+1. The earliest next accept is N+2, because an accept requires `!ack`.
- Burst of L beats with no waits: acks at N+1 … N+L, IDLE at N+L+1. Throughput is 1 word per clock.
- Wait state: `stb` low at M gives `ack` low at M+1; `stb` high at P gives `ack` at P+1.
- Read data is registered RAM output; there is no combinational path from `wbs_adr_i` to `wbs_dat_o`.
- `oor_cnt` updates in the cycle after the ack of the counted beat.

## Structure
- `sd_wb_pkg` holds:
  - `CTI_CLASSIC = 3'b000`, `CTI_INCR = 3'b010`, `CTI_EOB = 3'b111`, `BTE_LINEAR = 2'b00`;
  - the state encoding;
  - `ADDR_W = $clog2(MEM_WORDS)`.
- One sub-module, `sd_wb_store_ram`: single-port synchronous RAM with a 4-bit byte write enable. It is instantiated once, infers BRAM, and has no reset.

## Test plan
- Single write 32'hDEADBEEF at `BASE_ADDR + 8`, sel 1111, then single read at the same address → ack one cycle after each strobe, read returns 32'hDEADBEEF.
- Partial write 32'h11223344, sel 0101, over 32'hFFFFFFFF → read returns 32'hFF22FF44.
- 128-beat write burst, then 128-beat read burst (one 512-byte block) starting at word 0 → acks on 128 consecutive cycles, data matches, `busy` low on the cycle after the last ack.
- Read burst with `stb` low for 3 cycles after beat 5 → `ack` low for exactly 3 cycles, beat 6 returns word 6 with no beat skipped or repeated.
- Burst starting at word `MEM_WORDS - 2`, 4 beats → words MEM_WORDS-2 and MEM_WORDS-1 read correctly, beats 3 and 4 return 0, `oor_cnt = 2`; a read at `BASE_ADDR - 4` → `oor_cnt = 3`.
- Write burst: `reset_n` low after 3 of 8 acked beats, then read back → only words 0–2 changed; all outputs are at reset values on the edge after reset is sampled.
